// File: rtl/c3aibadapt_sr_pkg.sv
// Shared definitions for the adapter shift-register chain sequencer.
//   sr_state_e  : sequencer FSM encoding (IDLE/LOAD/SHIFT/GAP)
//   *_DEF       : default chain length, counter width and inter-frame gap
//   FRMCNT_W    : width of the optional completed-frame counter
package c3aibadapt_sr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_GAP   = 2'b11
  } sr_state_e;

  localparam int unsigned SR_LEN_DEF  = 64;
  localparam int unsigned CNT_W_DEF   = 7;
  localparam int unsigned GAP_CYC_DEF = 2;
  localparam int unsigned FRMCNT_W    = 16;

endpackage

// File: rtl/c3aibadapt_sr_ctrl_cnt.sv
// Loadable up/down counter shared by the sequencer for the bit index (up)
// and the inter-frame gap (down).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count resets to 0)
//   i_ld       : load i_ld_val (highest priority)
//   i_inc      : increment by one
//   i_dec      : decrement by one (lowest priority)
//   o_cnt      : current count
module c3aibadapt_sr_ctrl_cnt #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end else if (i_dec) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/c3aibadapt_sr_ctrl.sv
// Sequencer for the adapter serial shift-register chain. Drives the chain's
// common load select and frames each capture-then-shift transfer of SR_LEN
// bits, in single-shot (sr_req/sr_ack) or continuous (sr_cont) operation.
// Optional feature macro: C3AIBADAPT_SR_CTRL_FRMCNT_EN adds a 16-bit
// completed-frame counter (sr_frame_cnt) with synchronous clear.
// Ports:
//   clk, rst_n       : chain clock; asynchronous active-low reset
//   sr_req           : level request for one frame
//   sr_cont          : continuous mode, sampled at the last bit of each frame
//   sr_load          : 1 = chain captures parallel data, 0 = chain shifts
//   sr_busy          : high in LOAD/SHIFT/GAP
//   sr_sout_vld      : chain serial output carries a valid frame bit
//   sr_bit_idx       : index of the bit on the serial output
//   sr_frame_start   : one-cycle pulse in the LOAD cycle
//   sr_ack           : one-cycle pulse in the cycle after the last SHIFT
//   sr_frame_cnt_clr : (feature) synchronous clear of the frame counter
//   sr_frame_cnt     : (feature) completed-frame count, wraps at 0xFFFF
module c3aibadapt_sr_ctrl
  import c3aibadapt_sr_pkg::*;
#(
  parameter int unsigned SR_LEN  = SR_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sr_req,
  input  logic                sr_cont,
`ifdef C3AIBADAPT_SR_CTRL_FRMCNT_EN
  input  logic                sr_frame_cnt_clr,
  output logic [FRMCNT_W-1:0] sr_frame_cnt,
`endif
  output logic                sr_load,
  output logic                sr_busy,
  output logic                sr_sout_vld,
  output logic [CNT_W-1:0]    sr_bit_idx,
  output logic                sr_frame_start,
  output logic                sr_ack
);

  // The shared counter must also hold the gap count (up to 15).
  localparam int unsigned CW = (CNT_W > 4) ? CNT_W : 4;
  localparam logic [CW-1:0] LAST_IDX = CW'(SR_LEN - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  sr_state_e       r_state;
  sr_state_e       w_state_nxt;
  logic            r_ack;
  logic [CW-1:0]   w_cnt;
  logic            w_cnt_ld;
  logic [CW-1:0]   w_cnt_ld_val;
  logic            w_cnt_inc;
  logic            w_cnt_dec;
  logic            w_last;

  c3aibadapt_sr_ctrl_cnt #(
    .W (CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ld     (w_cnt_ld),
    .i_ld_val (w_cnt_ld_val),
    .i_inc    (w_cnt_inc),
    .i_dec    (w_cnt_dec),
    .o_cnt    (w_cnt)
  );

  assign w_last = (w_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (r_state == ST_SHIFT) && w_last;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_ld       = 1'b0;
    w_cnt_ld_val   = '0;
    w_cnt_inc      = 1'b0;
    w_cnt_dec      = 1'b0;
    sr_load        = 1'b1;
    sr_busy        = 1'b1;
    sr_sout_vld    = 1'b0;
    sr_frame_start = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        sr_busy  = 1'b0;
        w_cnt_ld = 1'b1;
        if (sr_req) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_frame_start = 1'b1;
        w_cnt_ld       = 1'b1;
        w_state_nxt    = ST_SHIFT;
      end
      ST_SHIFT: begin
        sr_load     = 1'b0;
        sr_sout_vld = 1'b1;
        if (w_last) begin
          w_cnt_ld = 1'b1;
          if (sr_cont && (GAP_CYC > 0)) begin
            w_cnt_ld_val = GAP_LD;
            w_state_nxt  = ST_GAP;
          end else if (sr_cont) begin
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_GAP: begin
        // Counter was loaded with GAP_CYC-1 and counts down to 0.
        if (w_cnt == '0) begin
          w_cnt_ld    = 1'b1;
          w_state_nxt = (sr_cont || sr_req) ? ST_LOAD : ST_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign sr_bit_idx = (r_state == ST_SHIFT) ? w_cnt[CNT_W-1:0] : '0;
  assign sr_ack     = r_ack;

`ifdef C3AIBADAPT_SR_CTRL_FRMCNT_EN
  logic [FRMCNT_W-1:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (sr_frame_cnt_clr) begin
      r_frame_cnt <= '0;
    end else if (r_ack) begin
      r_frame_cnt <= r_frame_cnt + FRMCNT_W'(1);
    end
  end

  assign sr_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_c3aibadapt_sr_ctrl.sv
// Scoreboard bench for c3aibadapt_sr_ctrl. Two instances with SR_LEN=8:
// u_g2 (GAP_CYC=2) and u_g0 (GAP_CYC=0). Each drives a chain model; frames
// are predicted from the request schedule and checked by a monitor.
module tb_c3aibadapt_sr_ctrl;

  localparam int SR_LEN = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       req0, cont0, load0, busy0, vld0, fs0, ack0;
  logic       req1, cont1, load1, busy1, vld1, fs1, ack1;
  logic [2:0] idx0, idx1;
  logic [7:0] par0, par1;
  logic [7:0] ch0, ch1;
`ifdef C3AIBADAPT_SR_CTRL_FRMCNT_EN
  logic        clr0, clr1;
  logic [15:0] fc0, fc1;
`endif

  c3aibadapt_sr_ctrl #(.SR_LEN(SR_LEN), .CNT_W(3), .GAP_CYC(2)) u_g2 (
    .clk(clk), .rst_n(rst_n), .sr_req(req0), .sr_cont(cont0),
`ifdef C3AIBADAPT_SR_CTRL_FRMCNT_EN
    .sr_frame_cnt_clr(clr0), .sr_frame_cnt(fc0),
`endif
    .sr_load(load0), .sr_busy(busy0), .sr_sout_vld(vld0), .sr_bit_idx(idx0),
    .sr_frame_start(fs0), .sr_ack(ack0));

  c3aibadapt_sr_ctrl #(.SR_LEN(SR_LEN), .CNT_W(3), .GAP_CYC(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .sr_req(req1), .sr_cont(cont1),
`ifdef C3AIBADAPT_SR_CTRL_FRMCNT_EN
    .sr_frame_cnt_clr(clr1), .sr_frame_cnt(fc1),
`endif
    .sr_load(load1), .sr_busy(busy1), .sr_sout_vld(vld1), .sr_bit_idx(idx1),
    .sr_frame_start(fs1), .sr_ack(ack1));

  // Chain model: capture when load, otherwise shift toward the MSB (serial out).
  always @(posedge clk) begin
    ch0 <= load0 ? par0 : {ch0[6:0], 1'b0};
    ch1 <= load1 ? par1 : {ch1[6:0], 1'b0};
  end

  typedef struct {
    int         dut;
    int         start;
    logic [7:0] data;
    bit         abort;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad   = 0;

  bit         inf[2];
  bit         ab[2];
  int         st[2];
  int         nb[2];
  logic [7:0] got[2];
  logic [7:0] want[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic mon(input int d, input logic fs, input logic vld, input logic ack,
                     input logic [2:0] idx, input logic sout);
    exp_t e;
    if (ack) begin
      if (!inf[d] || ab[d]) chk("stray_ack", ack, 0);
      else begin
        chk("ack_cycle", cyc, st[d] + SR_LEN + 1);
        chk("bit_count", nb[d], SR_LEN);
        chk("frame_data", got[d], want[d]);
      end
      inf[d] = 1'b0;
    end
    if (vld) begin
      if (!inf[d]) chk("stray_vld", vld, 0);
      else begin
        chk("bit_idx", idx, nb[d]);
        got[d] = {got[d][6:0], sout};
        nb[d]++;
      end
    end
    if (fs) begin
      if (expq.size() == 0 || expq[0].dut != d) chk("stray_start", fs, 0);
      else begin
        e = expq.pop_front();
        chk("start_cycle", cyc, e.start);
        inf[d]  = 1'b1;
        ab[d]   = e.abort;
        st[d]   = cyc;
        nb[d]   = 0;
        got[d]  = '0;
        want[d] = e.data;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      inf[0] = 1'b0;
      inf[1] = 1'b0;
    end else begin
      mon(0, fs0, vld0, ack0, idx0, ch0[7]);
      mon(1, fs1, vld1, ack1, idx1, ch1[7]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push(input int d, input int s, input logic [7:0] data, input bit abort);
    exp_t e;
    e.dut = d; e.start = s; e.data = data; e.abort = abort;
    expq.push_back(e);
  endtask

  // One request pulse; returns after the ack cycle plus a random idle spell.
  task automatic single(input int d, input logic [7:0] data);
    int c;
    c = cyc;
    push(d, c + 1, data, 1'b0);
    if (d == 0) begin par0 = data; req0 = 1'b1; end
    else        begin par1 = data; req1 = 1'b1; end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    wait_until(c + 10 + int'($urandom_range(1, 4)));
  endtask

  // Continuous run of n frames with period per; sr_cont dropped in the last.
  task automatic cont_run(input int d, input int n, input int per);
    int c;
    logic [7:0] dv[4];
    c = cyc;
    for (int k = 0; k < n; k++) begin
      dv[k] = 8'($urandom);
      push(d, c + 1 + per * k, dv[k], 1'b0);
    end
    if (d == 0) begin par0 = dv[0]; req0 = 1'b1; cont0 = 1'b1; end
    else        begin par1 = dv[0]; req1 = 1'b1; cont1 = 1'b1; end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    for (int k = 0; k < n - 1; k++) begin
      wait_until(c + 1 + per * k + 2);
      if (d == 0) par0 = dv[k + 1]; else par1 = dv[k + 1];
    end
    wait_until(c + 1 + per * (n - 1) + 4);
    cont0 = 1'b0;
    cont1 = 1'b0;
    wait_until(c + 1 + per * (n - 1) + 9 + 12);
    chk("stopped_busy", (d == 0) ? busy0 : busy1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [7:0] dv;
    rst_n = 1'b0;
    req0 = 1'b0; cont0 = 1'b0; par0 = 8'($urandom);
    req1 = 1'b0; cont1 = 1'b0; par1 = 8'($urandom);
`ifdef C3AIBADAPT_SR_CTRL_FRMCNT_EN
    clr0 = 1'b0; clr1 = 1'b0;
`endif
    repeat (5) tick();
    rst_n = 1'b1;

    // Idle after reset
    repeat (20) begin
      tick();
      chk("idle_load0", load0, 1); chk("idle_busy0", busy0, 0);
      chk("idle_vld0", vld0, 0);   chk("idle_ack0", ack0, 0);
      chk("idle_load1", load1, 1); chk("idle_busy1", busy1, 0);
      chk("idle_vld1", vld1, 0);   chk("idle_idx1", idx1, 0);
    end

    // Single frames with random data on both instances
    for (int i = 0; i < 4; i++) begin
      single(i % 2, 8'($urandom));
    end
    single(0, 8'hA5);

    // Continuous with gap, then back-to-back
    cont_run(0, 3, 11);
    cont_run(1, 4, 9);

    // sr_req held through a frame end without sr_cont: one IDLE cycle between
    c = cyc;
    dv = 8'($urandom);
    push(1, c + 1, dv, 1'b0);
    par1 = dv;
    req1 = 1'b1;
    dv = 8'($urandom);
    push(1, c + 11, dv, 1'b0);
    wait_until(c + 3);
    par1 = dv;
    wait_until(c + 11 + 3);
    req1 = 1'b0;
    wait_until(c + 11 + 9 + 5);
    chk("held_req_stop", busy1, 0);

    // Asynchronous reset in the middle of a frame
    c = cyc;
    push(0, c + 1, 8'h00, 1'b1);
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    for (int i = 0; i < 20 && !(vld0 === 1'b1 && idx0 === 3'd4); i++) @(negedge clk);
    chk("reached_idx4", idx0, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_load", load0, 1); chk("rst_busy", busy0, 0);
    chk("rst_vld", vld0, 0);   chk("rst_idx", idx0, 0);
    chk("rst_fs", fs0, 0);     chk("rst_ack", ack0, 0);
    repeat (3) tick();
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    single(0, 8'($urandom));

`ifdef C3AIBADAPT_SR_CTRL_FRMCNT_EN
    // Frame counter: three frames, then clear coinciding with the ack
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) single(0, 8'($urandom));
    chk("frame_cnt3", fc0, 3);
    chk("frame_cnt_other", fc1, 0);
    c = cyc;
    push(0, c + 1, 8'h3C, 1'b0);
    par0 = 8'h3C;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    wait_until(c + 10);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    tick();
    chk("frame_cnt_clr", fc0, 0);
`endif

    repeat (5) tick();
    chk("queue_empty", expq.size(), 0);
    chk("no_inflight0", inf[0], 0);
    chk("no_inflight1", inf[1], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
